// File: rtl/ripplecarry_add.sv
// 4-bit ripple-carry adder with registered sum and per-stage carry outputs.
`timescale 1ns/1ps

// One full-adder cell. It is reused for every bit of the ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic prop;

  // Propagate term, sum and carry for a single bit
  always_comb begin
    prop = a ^ b;
    s    = prop ^ cin;
    cout = (a & b) | (cin & prop);
  end

endmodule

// Top level: four chained cells feed one bank of output registers.
module ripplecarry_add (
  input  logic clk,
  input  logic rst,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic B0,
  input  logic B1,
  input  logic B2,
  input  logic B3,
  input  logic Cin,
  output logic S0,
  output logic S1,
  output logic S2,
  output logic S3,
  output logic C1,
  output logic C2,
  output logic C3,
  output logic C4
);

  localparam int unsigned W = 4;

  logic [W-1:0] a_vec;
  logic [W-1:0] b_vec;
  logic [W-1:0] sum_c;
  logic [W:0]   carry_c;

  // Gather the loose operand bits into vectors, LSB first
  always_comb begin
    a_vec      = {A3, A2, A1, A0};
    b_vec      = {B3, B2, B1, B0};
    carry_c[0] = Cin;
  end

  fa_cell u_fa0 (
    .a    (a_vec[0]),
    .b    (b_vec[0]),
    .cin  (carry_c[0]),
    .s    (sum_c[0]),
    .cout (carry_c[1])
  );

  fa_cell u_fa1 (
    .a    (a_vec[1]),
    .b    (b_vec[1]),
    .cin  (carry_c[1]),
    .s    (sum_c[1]),
    .cout (carry_c[2])
  );

  fa_cell u_fa2 (
    .a    (a_vec[2]),
    .b    (b_vec[2]),
    .cin  (carry_c[2]),
    .s    (sum_c[2]),
    .cout (carry_c[3])
  );

  fa_cell u_fa3 (
    .a    (a_vec[3]),
    .b    (b_vec[3]),
    .cin  (carry_c[3]),
    .s    (sum_c[3]),
    .cout (carry_c[4])
  );

  // Capture all eight results together; reset clears them at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S0 <= 1'b0;
      S1 <= 1'b0;
      S2 <= 1'b0;
      S3 <= 1'b0;
      C1 <= 1'b0;
      C2 <= 1'b0;
      C3 <= 1'b0;
      C4 <= 1'b0;
    end else begin
      S0 <= sum_c[0];
      S1 <= sum_c[1];
      S2 <= sum_c[2];
      S3 <= sum_c[3];
      C1 <= carry_c[1];
      C2 <= carry_c[2];
      C3 <= carry_c[3];
      C4 <= carry_c[4];
    end
  end

endmodule

// File: tb/tb_ripplecarry_add.sv
// Self-checking bench for ripplecarry_add: directed cases, reset behaviour,
// exhaustive sweep and randomized traffic against an arithmetic model.
`timescale 1ns/1ps

module tb_ripplecarry_add;

  logic clk;
  logic rst;
  logic A0, A1, A2, A3;
  logic B0, B1, B2, B3;
  logic Cin;
  logic S0, S1, S2, S3;
  logic C1, C2, C3, C4;

  int checks;
  int failures;

  ripplecarry_add dut (
    .clk (clk),
    .rst (rst),
    .A0  (A0),
    .A1  (A1),
    .A2  (A2),
    .A3  (A3),
    .B0  (B0),
    .B1  (B1),
    .B2  (B2),
    .B3  (B3),
    .Cin (Cin),
    .S0  (S0),
    .S1  (S1),
    .S2  (S2),
    .S3  (S3),
    .C1  (C1),
    .C2  (C2),
    .C3  (C3),
    .C4  (C4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs packed as {C4,C3,C2,C1,S3,S2,S1,S0}
  function automatic logic [7:0] observed();
    return {C4, C3, C2, C1, S3, S2, S1, S0};
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got={C4..C1,S3..S0}=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer addition; carry out of bit i-1 means the
  // low i bits of A + B + Cin reach 2**i.
  function automatic logic [7:0] ref_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic cin);
    int unsigned total;
    int unsigned part;
    int unsigned mask;
    logic [3:0] carries;
    total = int'(a) + int'(b) + int'(cin);
    for (int i = 1; i <= 4; i++) begin
      mask = (32'd1 << i) - 32'd1;
      part = (int'(a) & mask) + (int'(b) & mask) + int'(cin);
      carries[i-1] = (part >= (32'd1 << i));
    end
    return {carries, 4'(total % 16)};
  endfunction

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic cin);
    {A3, A2, A1, A0} = a;
    {B3, B2, B1, B0} = b;
    Cin = cin;
  endtask

  // Apply operands, let one rising edge pass, compare against expectation
  task automatic step_check(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic cin, input logic [7:0] exp);
    drive(a, b, cin);
    @(posedge clk);
    #1;
    check_eq(tag, observed(), exp);
  endtask

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    logic       rc;
    logic [7:0] exp;
    checks   = 0;
    failures = 0;

    // Reset is visible before any clock edge
    rst = 1'b1;
    drive(4'd9, 4'd9, 1'b1);
    #1;
    check_eq("reset_async", observed(), 8'h00);
    @(posedge clk);
    #1;
    check_eq("reset_edge", observed(), 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Directed scenarios
    step_check("dir_0p0",    4'b0000, 4'b0000, 1'b0, 8'b0000_0000);
    step_check("dir_3p5",    4'b0011, 4'b0101, 1'b0, 8'b0111_1000);
    step_check("dir_15p1",   4'b1111, 4'b0001, 1'b0, 8'b1111_0000);
    step_check("dir_0p0c1",  4'b0000, 4'b0000, 1'b1, 8'b0000_0001);
    step_check("dir_31",     4'b1111, 4'b1111, 1'b1, 8'b1111_1111);

    // Mid-operation reset between edges clears immediately
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_mid", observed(), 8'h00);
    @(posedge clk);
    #1;
    check_eq("rst_hold_edge", observed(), 8'h00);
    drive(4'b0011, 4'b0101, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_3p5", observed(), 8'b0111_1000);

    // Exhaustive sweep of all operand combinations
    for (int i = 0; i < 512; i++) begin
      ra = 4'(i);
      rb = 4'(i >> 4);
      rc = 1'(i >> 8);
      step_check("sweep", ra, rb, rc, ref_model(ra, rb, rc));
    end

    // Randomized traffic with a hold check between edges
    for (int i = 0; i < 200; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rc  = 1'($urandom_range(0, 1));
      exp = ref_model(ra, rb, rc);
      step_check("rand", ra, rb, rc, exp);
      drive(~ra, 4'($urandom_range(0, 15)), ~rc);
      #2;
      check_eq("rand_hold", observed(), exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
